// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the PC fetch sequencer.
package pc_seq_pkg;

  localparam int unsigned ADDR_W_DEF    = 16;
  localparam int unsigned INC_DEF       = 4;
  localparam logic [15:0] RESET_VEC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold,
    StHalted
  } fetch_state_e;

  typedef enum logic [1:0] {
    SrcNone,
    SrcBr,
    SrcJump,
    SrcTrap
  } redir_src_e;

endpackage

// File: rtl/pc_next_sel.sv
// Priority select of the redirect target and its source (trap > jump > branch).
// The trap input and TRAP_VEC exist only when PCSEQ_TRAP_EN is defined.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
`ifdef PCSEQ_TRAP_EN
  ,
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(16'h0010)
`endif
) (
`ifdef PCSEQ_TRAP_EN
  input  logic              trap_req,
`endif
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_add,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_add,
  output logic [1:0]        redir_src,
  output logic [ADDR_W-1:0] redir_add
);

  // Later assignments override earlier ones, giving the priority order.
  always_comb begin
    redir_src = SrcNone;
    redir_add = br_add;
    if (br_take) begin
      redir_src = SrcBr;
      redir_add = br_add;
    end
    if (jump) begin
      redir_src = SrcJump;
      redir_add = jump_add;
    end
`ifdef PCSEQ_TRAP_EN
    if (trap_req) begin
      redir_src = SrcTrap;
      redir_add = TRAP_VEC;
    end
`endif
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Owns the PC and sequences req/ack fetches, buffering and squashing on redirects.
// Optional trap redirect enabled by defining PCSEQ_TRAP_EN.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       INC       = INC_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
`ifdef PCSEQ_TRAP_EN
  ,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(16'h0010)
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              halt,
  input  logic              stall,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_add,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_add,
`ifdef PCSEQ_TRAP_EN
  input  logic              trap_req,
`endif
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              redirect_pending
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] pend_add_q, pend_add_d;
  logic              pend_q, pend_d;
  logic              halt_seen_q, halt_seen_d;
  logic              req_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;

  logic [1:0]        redir_src;
  logic [ADDR_W-1:0] redir_add;
  logic              redir;

  pc_next_sel #(
    .ADDR_W   (ADDR_W)
`ifdef PCSEQ_TRAP_EN
    ,
    .TRAP_VEC (TRAP_VEC)
`endif
  ) u_next_sel (
`ifdef PCSEQ_TRAP_EN
    .trap_req  (trap_req),
`endif
    .br_take   (br_take),
    .br_add    (br_add),
    .jump      (jump),
    .jump_add  (jump_add),
    .redir_src (redir_src),
    .redir_add (redir_add)
  );

  assign redir = (redir_src != SrcNone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fetch_addr_q <= RESET_VEC;
      pend_add_q   <= '0;
      pend_q       <= 1'b0;
      halt_seen_q  <= 1'b0;
      req_q        <= 1'b0;
      pc_q         <= RESET_VEC;
      pc_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pend_add_q   <= pend_add_d;
      pend_q       <= pend_d;
      halt_seen_q  <= halt_seen_d;
      req_q        <= (state_d == StReq);
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (halt) begin
          state_d = StHalted;
        end else if (run && !stall) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (imem_ack) begin
          if (halt_seen_q || halt) begin
            state_d = StHalted;
          end else if (!run) begin
            state_d = StIdle;
          end else if (stall) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (halt) begin
          state_d = StHalted;
        end else if (!stall) begin
          state_d = run ? StReq : StIdle;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    pend_add_d   = pend_add_q;
    pend_d       = pend_q;
    halt_seen_d  = halt_seen_q;
    pc_d         = pc_q;
    pc_valid_d   = 1'b0;
    unique case (state_q)
      StIdle, StHold: begin
        // No fetch in flight, so a redirect retargets the next fetch directly.
        if (redir) begin
          fetch_addr_d = redir_add;
        end
      end
      StReq: begin
        if (halt) begin
          halt_seen_d = 1'b1;
        end
        if (imem_ack) begin
          halt_seen_d = 1'b0;
          pend_d      = 1'b0;
          if (redir) begin
            fetch_addr_d = redir_add;
          end else if (pend_q) begin
            fetch_addr_d = pend_add_q;
          end else begin
            pc_d         = fetch_addr_q;
            pc_valid_d   = 1'b1;
            fetch_addr_d = fetch_addr_q + ADDR_W'(INC);
          end
        end else if (redir) begin
          // Hold imem_addr stable; remember only the newest redirect.
          pend_d     = 1'b1;
          pend_add_d = redir_add;
        end
      end
      default: ;
    endcase
  end

  assign imem_req         = req_q;
  assign imem_addr        = fetch_addr_q;
  assign pc               = pc_q;
  assign pc_valid         = pc_valid_q;
  assign redirect_pending = pend_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: directed test-plan sequences plus random traffic
// checked against a transaction-level reference model.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run, halt, stall, br_take, jump, imem_ack;
  logic [15:0] br_add, jump_add;
  logic        trap_req;
  logic        imem_req, pc_valid, redirect_pending;
  logic [15:0] imem_addr, pc;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: fetch activity flags, next fetch address and one-entry redirect buffer.
  logic        m_req, m_hold, m_halted, m_halt_seen, m_pend;
  logic [15:0] m_addr, m_pend_tgt;
  logic [15:0] exp_pc[$];

  pc_fetch_sequencer u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .run              (run),
    .halt             (halt),
    .stall            (stall),
    .br_take          (br_take),
    .br_add           (br_add),
    .jump             (jump),
    .jump_add         (jump_add),
`ifdef PCSEQ_TRAP_EN
    .trap_req         (trap_req),
`endif
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .pc               (pc),
    .pc_valid         (pc_valid),
    .redirect_pending (redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_req       = 1'b0;
    m_hold      = 1'b0;
    m_halted    = 1'b0;
    m_halt_seen = 1'b0;
    m_pend      = 1'b0;
    m_addr      = 16'h0000;
    m_pend_tgt  = 16'h0000;
    exp_pc.delete();
  endtask

  task automatic model_step();
    logic        redir;
    logic [15:0] tgt;
    redir = jump || br_take;
    tgt   = jump ? jump_add : br_add;
    if (m_halted) return;
    if (m_req) begin
      if (halt) m_halt_seen = 1'b1;
      if (!imem_ack) begin
        if (redir) begin
          m_pend     = 1'b1;
          m_pend_tgt = tgt;
        end
      end else begin
        if (redir) m_addr = tgt;
        else if (m_pend) m_addr = m_pend_tgt;
        else begin
          exp_pc.push_back(m_addr);
          m_addr = m_addr + 16'd4;
        end
        m_pend = 1'b0;
        if (m_halt_seen) begin
          m_halted = 1'b1;
          m_req    = 1'b0;
        end else if (!run) begin
          m_req = 1'b0;
        end else if (stall) begin
          m_req  = 1'b0;
          m_hold = 1'b1;
        end
      end
    end else begin
      if (redir) m_addr = tgt;
      if (m_hold) begin
        if (halt) begin
          m_halted = 1'b1;
          m_hold   = 1'b0;
        end else if (!stall) begin
          m_hold = 1'b0;
          m_req  = run;
        end
      end else if (halt) begin
        m_halted = 1'b1;
      end else if (run && !stall) begin
        m_req = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", {15'd0, imem_req}, {15'd0, m_req});
    chk("imem_addr", imem_addr, m_addr);
    chk("redirect_pending", {15'd0, redirect_pending}, {15'd0, m_pend});
  endtask

  // Apply one cycle of inputs at the falling edge, advance the model, check after the next edge.
  task automatic drive(input logic r, input logic h, input logic s, input logic b,
                       input logic [15:0] ba, input logic j, input logic [15:0] ja,
                       input logic a);
    run = r; halt = h; stall = s; br_take = b; br_add = ba;
    jump = j; jump_add = ja; imem_ack = a;
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_imem_req"}, {15'd0, imem_req}, 16'd0);
    chk({tag, "_imem_addr"}, imem_addr, 16'h0000);
    chk({tag, "_pc"}, pc, 16'h0000);
    chk({tag, "_pc_valid"}, {15'd0, pc_valid}, 16'd0);
    chk({tag, "_redirect_pending"}, {15'd0, redirect_pending}, 16'd0);
  endtask

  // Monitor: every pc_valid pulse must match the oldest accepted fetch.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && pc_valid) begin
        if (exp_pc.size() == 0) begin
          chk("pc_valid_unexpected", 16'd1, 16'd0);
        end else begin
          e = exp_pc.pop_front();
          chk("pc", pc, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; halt = 1'b0; stall = 1'b0; br_take = 1'b0; jump = 1'b0;
    br_add = 16'h0; jump_add = 16'h0; imem_ack = 1'b1; trap_req = 1'b0;
    model_reset();
    @(negedge clk);
    chk_reset_values("reset");
    run = 1'b1;
    @(negedge clk);
    chk("reset_ack_ignored", {15'd0, imem_req}, 16'd0);

    // Back-to-back sequential fetches with ack tied high.
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 1);
    chk("seq_addr0", imem_addr, 16'h0000);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 1);
    chk("seq_addr1", imem_addr, 16'h0004);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 1);
    chk("seq_addr2", imem_addr, 16'h0008);

    // Jump beats branch; the acked fetch is squashed.
    drive(1, 0, 0, 1, 16'h0200, 1, 16'h0100, 1);
    chk("squash_addr", imem_addr, 16'h0100);

    // Redirect while a fetch is outstanding goes to the buffer.
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0);
    drive(1, 0, 0, 1, 16'h0040, 0, 16'h0, 0);
    chk("pend_set", {15'd0, redirect_pending}, 16'd1);
    chk("pend_addr_stable", imem_addr, 16'h0100);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 1);
    chk("pend_target", imem_addr, 16'h0040);
    chk("pend_clear", {15'd0, redirect_pending}, 16'd0);

    // Address wraps modulo 2^16.
    drive(1, 0, 0, 0, 16'h0, 1, 16'hFFFC, 1);
    chk("wrap_start", imem_addr, 16'hFFFC);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 1);
    chk("wrap_addr", imem_addr, 16'h0000);

    // Stall completes the fetch, redirect in HOLD loads directly.
    drive(1, 0, 1, 0, 16'h0, 0, 16'h0, 0);
    drive(1, 0, 1, 0, 16'h0, 0, 16'h0, 1);
    chk("hold_req_low", {15'd0, imem_req}, 16'd0);
    drive(1, 0, 1, 0, 16'h0, 1, 16'h0020, 0);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0);
    chk("hold_exit_req", {15'd0, imem_req}, 16'd1);
    chk("hold_exit_addr", imem_addr, 16'h0020);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(99, 0) < 90, 1'b0, $urandom_range(99, 0) < 20,
            $urandom_range(99, 0) < 15, 16'($urandom), $urandom_range(99, 0) < 10,
            16'($urandom), $urandom_range(99, 0) < 60);
    end

    // Asynchronous reset in the middle of a fetch.
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    model_reset();
    imem_ack = 1'b1;
    @(negedge clk);
    chk("async_reset_ack_ignored", {15'd0, imem_req}, 16'd0);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 1);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 1);

    // Halt mid-fetch: the fetch completes, then no more requests.
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0);
    drive(1, 1, 0, 0, 16'h0, 0, 16'h0, 0);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, $urandom_range(1, 0) == 1, 16'($urandom), 0, 16'h0, 1);
    end
    chk("halted_req_low", {15'd0, imem_req}, 16'd0);
    chk("pc_queue_drained", 16'(exp_pc.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
